// File: rtl/pipelined_reduction_tree.sv
// Lane reducer: masked log2-depth adder tree with configurable register placement,
// valid/ready flow control and an output accumulator that folds multi-beat groups.
module pipelined_reduction_tree #(
    parameter int unsigned NUM_IN      = 16,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned PIPE_STRIDE = 1,
    parameter int unsigned ADD_MODE    = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]           in_mask,
    input  logic                        in_acc,
    input  logic                        in_last,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATAWIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]            out_count
);

    localparam int unsigned STAGES = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);
    localparam int unsigned PAD    = 1 << STAGES;
    localparam int unsigned STRIDE = (PIPE_STRIDE == 0) ? 1 : PIPE_STRIDE;

    // Binary32 add: denormals flush to zero, result truncated toward zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey, d;
        logic [27:0] mx, my, s;
        logic [8:0]  e;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = x[30:23];
        ey = y[30:23];
        if (ex == 8'hFF) return x;
        if (ex == 8'h00) return 32'h0;
        if (ey == 8'h00) return x;
        mx = {1'b0, 1'b1, x[22:0], 3'b000};
        d  = ex - ey;
        my = (d > 8'd26) ? 28'h0 : ({1'b0, 1'b1, y[22:0], 3'b000} >> d);
        e  = {1'b0, ex};
        if (x[31] == y[31]) begin
            s = mx + my;
            if (s[27]) begin
                s = s >> 1;
                e = e + 9'd1;
            end
            if (e >= 9'd255) return {x[31], 8'hFF, 23'h0};
        end else begin
            s = mx - my;
            if (s == 28'h0) return 32'h0;
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 9'd1) begin
                    s = s << 1;
                    e = e - 9'd1;
                end
            end
            if (!s[26]) return {x[31], 31'h0};
        end
        return {x[31], e[7:0], s[25:3]};
    endfunction

    function automatic logic [DATAWIDTH-1:0] add_op(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
        if (ADD_MODE == 1) return DATAWIDTH'(fp_add(32'(a), 32'(b)));
        return a + b;
    endfunction

    logic advance;
    logic accept;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;
    assign accept   = in_valid && in_ready;

    // Level s holds PAD>>s partial sums; registered levels carry valid/acc/last alongside.
    for (genvar s = 0; s <= STAGES; s++) begin : g_lvl
        localparam int unsigned N = PAD >> s;
        logic [DATAWIDTH-1:0] val [N];
        logic                 v;
        logic                 a;
        logic                 l;

        if (s == 0) begin : g_in
            for (genvar j = 0; j < PAD; j++) begin : g_lane
                if (j < NUM_IN) begin : g_real
                    assign val[j] = in_mask[j] ? in_data[j*DATAWIDTH +: DATAWIDTH] : '0;
                end else begin : g_pad
                    assign val[j] = '0;
                end
            end
            assign v = accept;
            assign a = in_acc;
            assign l = in_acc && in_last;
        end else begin : g_add
            logic [DATAWIDTH-1:0] sum [N];
            for (genvar j = 0; j < N; j++) begin : g_node
                assign sum[j] = add_op(g_lvl[s-1].val[2*j], g_lvl[s-1].val[2*j+1]);
            end
            if ((PIPE_STRIDE > 0) && (((s % STRIDE) == 0) || (s == STAGES))) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v   <= 1'b0;
                        a   <= 1'b0;
                        l   <= 1'b0;
                        val <= '{default: '0};
                    end else if (flush) begin
                        v <= 1'b0;
                    end else if (advance) begin
                        v   <= g_lvl[s-1].v;
                        a   <= g_lvl[s-1].a;
                        l   <= g_lvl[s-1].l;
                        val <= sum;
                    end
                end
            end else begin : g_comb
                assign val = sum;
                assign v   = g_lvl[s-1].v;
                assign a   = g_lvl[s-1].a;
                assign l   = g_lvl[s-1].l;
            end
        end
    end

    logic [DATAWIDTH-1:0] t_data;
    logic                 t_valid;
    logic                 t_acc;
    logic                 t_last;
    logic [DATAWIDTH-1:0] acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 open_q;
    logic [DATAWIDTH-1:0] grp_sum;
    logic [CNT_W-1:0]     grp_cnt;

    assign t_data  = g_lvl[STAGES].val[0];
    assign t_valid = g_lvl[STAGES].v;
    assign t_acc   = g_lvl[STAGES].a;
    assign t_last  = g_lvl[STAGES].l;

    always_comb begin
        grp_sum = t_data;
        grp_cnt = CNT_W'(1);
        if (open_q) begin
            grp_sum = add_op(acc_q, t_data);
            grp_cnt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            open_q    <= 1'b0;
        end else if (flush) begin
            // Held result survives; one being consumed this cycle retires normally.
            acc_q  <= '0;
            cnt_q  <= '0;
            open_q <= 1'b0;
            if (out_ready) out_valid <= 1'b0;
        end else if (advance) begin
            if (!t_valid) begin
                out_valid <= 1'b0;
            end else if (!t_acc) begin
                out_data  <= t_data;
                out_count <= CNT_W'(1);
                out_valid <= 1'b1;
            end else if (t_last) begin
                out_data  <= grp_sum;
                out_count <= grp_cnt;
                out_valid <= 1'b1;
                acc_q     <= '0;
                cnt_q     <= '0;
                open_q    <= 1'b0;
            end else begin
                acc_q     <= grp_sum;
                cnt_q     <= grp_cnt;
                open_q    <= 1'b1;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
